uart_rx_stream_buffer: RTL and testbench

Receive-side byte FIFO placed directly downstream of the UART byte decoder.
- Drains each finished byte from the decoder through its ready/release handshake, so the decoder can return to idle and be ready for the next start bit.
- Holds received bytes in a circular buffer until a consumer (LED/display/command logic) pops them.
- Receive traffic cannot be backpressured, so bytes arriving while the buffer is full are dropped and the drop is flagged.

---
 rtl/uart_rx_stream_buffer.sv | 114 +++++++++++
 tb/tb_uart_rx_stream_buffer.sv | 209 ++++++++++++++++++++
 2 files changed

// File: rtl/uart_rx_stream_buffer.sv
// rtl/uart_rx_stream_buffer.sv - UART receive byte FIFO with decoder release handshake (option: UART_RX_STREAM_BUFFER_HIGH_WATER_EN)
module uart_rx_stream_buffer #(
    parameter int DEPTH_LOG2 = 4
) (
    input  logic                  i_Clk,
    input  logic                  i_Rst,
    input  logic [7:0]            i_Dec_Byte,
    input  logic                  i_Dec_Ready,
    output logic                  o_Dec_Release,
    input  logic                  i_Rd_En,
    output logic [7:0]            o_Rd_Byte,
    output logic                  o_Rd_Valid,
    output logic [DEPTH_LOG2:0]   o_Count,
`ifdef UART_RX_STREAM_BUFFER_HIGH_WATER_EN
    output logic [DEPTH_LOG2:0]   o_High_Water,
`endif
    output logic                  o_Full,
    output logic                  o_Overflow,
    input  logic                  i_Clear_Overflow
);

    localparam int DEPTH = 2 ** DEPTH_LOG2;
    localparam int CNT_W = DEPTH_LOG2 + 1;
    localparam logic [CNT_W-1:0] DEPTH_CNT = CNT_W'(DEPTH);
    localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);
    localparam logic [DEPTH_LOG2-1:0] PTR_ONE = DEPTH_LOG2'(1);

    logic [7:0]            r_Mem [DEPTH];
    logic [DEPTH_LOG2-1:0] r_Wr_Ptr;
    logic [DEPTH_LOG2-1:0] r_Rd_Ptr;
    logic [CNT_W-1:0]      r_Count;
    logic                  r_Release;
    logic                  r_Overflow;

    logic w_Capture;
    logic w_Rd;
    logic w_Wr;
    logic w_Drop;

    // Capture only while release is low so a byte still held during the release cycle is not taken twice;
    // a simultaneous pop frees a slot, so a full buffer still accepts the byte in that case.
    always_comb begin
        w_Capture = i_Dec_Ready && !r_Release;
        w_Rd      = i_Rd_En && (r_Count != '0);
        w_Wr      = w_Capture && ((r_Count < DEPTH_CNT) || w_Rd);
        w_Drop    = w_Capture && !w_Wr;
    end

    // Storage is never reset; only pointers and count define valid content.
    always_ff @(posedge i_Clk) begin
        if (w_Wr && !i_Rst) begin
            r_Mem[r_Wr_Ptr] <= i_Dec_Byte;
        end
    end

    // Pointers, fill count and the one-cycle decoder release pulse.
    always_ff @(posedge i_Clk) begin
        if (i_Rst) begin
            r_Wr_Ptr  <= '0;
            r_Rd_Ptr  <= '0;
            r_Count   <= '0;
            r_Release <= 1'b0;
        end else begin
            r_Release <= w_Capture;
            if (w_Wr) begin
                r_Wr_Ptr <= r_Wr_Ptr + PTR_ONE;
            end
            if (w_Rd) begin
                r_Rd_Ptr <= r_Rd_Ptr + PTR_ONE;
            end
            case ({w_Wr, w_Rd})
                2'b10:   r_Count <= r_Count + CNT_ONE;
                2'b01:   r_Count <= r_Count - CNT_ONE;
                default: r_Count <= r_Count;
            endcase
        end
    end

    // Sticky drop flag; a drop in the same cycle as a clear keeps the flag set.
    always_ff @(posedge i_Clk) begin
        if (i_Rst) begin
            r_Overflow <= 1'b0;
        end else if (w_Drop) begin
            r_Overflow <= 1'b1;
        end else if (i_Clear_Overflow) begin
            r_Overflow <= 1'b0;
        end
    end

`ifdef UART_RX_STREAM_BUFFER_HIGH_WATER_EN
    logic [CNT_W-1:0] r_High_Water;

    // Peak fill level, following the registered count one cycle later; clear re-bases it to the current level.
    always_ff @(posedge i_Clk) begin
        if (i_Rst) begin
            r_High_Water <= '0;
        end else if (i_Clear_Overflow) begin
            r_High_Water <= r_Count;
        end else if (r_Count > r_High_Water) begin
            r_High_Water <= r_Count;
        end
    end

    assign o_High_Water = r_High_Water;
`endif

    assign o_Dec_Release = r_Release;
    assign o_Rd_Byte     = r_Mem[r_Rd_Ptr];
    assign o_Rd_Valid    = (r_Count != '0);
    assign o_Count       = r_Count;
    assign o_Full        = (r_Count == DEPTH_CNT);
    assign o_Overflow    = r_Overflow;

endmodule

// File: tb/tb_uart_rx_stream_buffer.sv
// tb/tb_uart_rx_stream_buffer.sv - self-checking bench for uart_rx_stream_buffer
module tb_uart_rx_stream_buffer;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [7:0] dec_byte = 8'h00;
    logic       dec_ready = 1'b0;
    logic       dec_release;
    logic       rd_en = 1'b0;
    logic [7:0] rd_byte;
    logic       rd_valid;
    logic [4:0] count;
    logic       full;
    logic       overflow;
    logic       clr_ov = 1'b0;
`ifdef UART_RX_STREAM_BUFFER_HIGH_WATER_EN
    logic [4:0] high_water;
`endif

    int n_tests = 0;
    int n_fail  = 0;

    logic [7:0] q[$];
    logic       ov_exp = 1'b0;

    always #5 clk = ~clk;

    uart_rx_stream_buffer #(.DEPTH_LOG2(4)) dut (
        .i_Clk            (clk),
        .i_Rst            (rst),
        .i_Dec_Byte       (dec_byte),
        .i_Dec_Ready      (dec_ready),
        .o_Dec_Release    (dec_release),
        .i_Rd_En          (rd_en),
        .o_Rd_Byte        (rd_byte),
        .o_Rd_Valid       (rd_valid),
        .o_Count          (count),
`ifdef UART_RX_STREAM_BUFFER_HIGH_WATER_EN
        .o_High_Water     (high_water),
`endif
        .o_Full           (full),
        .o_Overflow       (overflow),
        .i_Clear_Overflow (clr_ov)
    );

    typedef struct {
        logic       rst;
        logic       ready;
        logic       rd;
        logic       clr;
        logic [7:0] din;
        logic       e_rel;
        logic [4:0] e_cnt;
        logic       e_valid;
        logic       e_full;
        logic       e_ov;
        logic [7:0] e_dout;
    } vec_t;

    vec_t vecs[12];

    task automatic chk(input string name, input int act, input int exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Decoder model: ready held through the release cycle, dropped after release is seen.
    task automatic send_byte(input logic [7:0] b, input logic rd, input logic clr);
        logic drop;
        dec_byte  = b;
        dec_ready = 1'b1;
        rd_en     = rd;
        clr_ov    = clr;
        if (rd && q.size() > 0) begin
            chk("pop_head", rd_byte, q.pop_front());
        end
        drop = (q.size() >= 16);
        if (!drop) q.push_back(b);
        if (drop) ov_exp = 1'b1;
        else if (clr) ov_exp = 1'b0;
        step();
        chk("release_pulse", dec_release, 1);
        rd_en  = 1'b0;
        clr_ov = 1'b0;
        step();
        chk("release_single", dec_release, 0);
        dec_ready = 1'b0;
        chk("count_after_send", count, q.size());
        chk("overflow_after_send", overflow, ov_exp);
    endtask

    task automatic pop_byte();
        chk("pop_valid", rd_valid, 1);
        chk("pop_head", rd_byte, q.pop_front());
        rd_en = 1'b1;
        step();
        rd_en = 1'b0;
        chk("pop_count", count, q.size());
    endtask

    initial begin
        //          rst ready rd clr din    rel cnt valid full ov dout
        vecs[0]  = '{1, 0, 0, 0, 8'h00,  0, 0, 0, 0, 0, 8'h00};
        vecs[1]  = '{0, 1, 0, 0, 8'h41,  1, 1, 1, 0, 0, 8'h41};
        vecs[2]  = '{0, 1, 0, 0, 8'h41,  0, 1, 1, 0, 0, 8'h41};
        vecs[3]  = '{0, 0, 0, 0, 8'h00,  0, 1, 1, 0, 0, 8'h41};
        vecs[4]  = '{0, 0, 1, 0, 8'h00,  0, 0, 0, 0, 0, 8'h00};
        vecs[5]  = '{0, 0, 1, 0, 8'h00,  0, 0, 0, 0, 0, 8'h00};
        vecs[6]  = '{0, 1, 1, 0, 8'h7E,  1, 1, 1, 0, 0, 8'h7E};
        vecs[7]  = '{0, 1, 0, 0, 8'h7E,  0, 1, 1, 0, 0, 8'h7E};
        vecs[8]  = '{0, 1, 0, 0, 8'h33,  1, 2, 1, 0, 0, 8'h7E};
        vecs[9]  = '{0, 0, 1, 0, 8'h00,  0, 1, 1, 0, 0, 8'h33};
        vecs[10] = '{0, 1, 1, 0, 8'h99,  1, 1, 1, 0, 0, 8'h99};
        vecs[11] = '{0, 0, 1, 0, 8'h00,  0, 0, 0, 0, 0, 8'h00};

        step();
        for (int i = 0; i < 12; i++) begin
            rst       = vecs[i].rst;
            dec_ready = vecs[i].ready;
            rd_en     = vecs[i].rd;
            clr_ov    = vecs[i].clr;
            dec_byte  = vecs[i].din;
            step();
            chk($sformatf("v%0d_release", i), dec_release, vecs[i].e_rel);
            chk($sformatf("v%0d_count", i), count, vecs[i].e_cnt);
            chk($sformatf("v%0d_valid", i), rd_valid, vecs[i].e_valid);
            chk($sformatf("v%0d_full", i), full, vecs[i].e_full);
            chk($sformatf("v%0d_overflow", i), overflow, vecs[i].e_ov);
            if (vecs[i].e_valid) begin
                chk($sformatf("v%0d_rd_byte", i), rd_byte, vecs[i].e_dout);
            end
        end
        rd_en = 1'b0;
        dec_ready = 1'b0;

        // Fill to full, then overflow with 0xAA.
        for (int i = 0; i < 16; i++) send_byte(8'(i), 1'b0, 1'b0);
        chk("full_flag", full, 1);
        chk("full_count", count, 16);
        chk("full_no_overflow", overflow, 0);
        send_byte(8'hAA, 1'b0, 1'b0);
        chk("drop_overflow", overflow, 1);
        chk("drop_count", count, 16);

        // Clear, then capture 0x55 with a simultaneous pop: no drop.
        clr_ov = 1'b1;
        step();
        clr_ov = 1'b0;
        ov_exp = 1'b0;
        chk("overflow_cleared", overflow, 0);
        send_byte(8'h55, 1'b1, 1'b0);
        chk("full_rd_wr_count", count, 16);
        chk("full_rd_wr_no_overflow", overflow, 0);

        // Drop coinciding with clear: flag stays set.
        send_byte(8'hBB, 1'b0, 1'b1);
        chk("drop_beats_clear", overflow, 1);

        // Drain: 0x01..0x0F then 0x55.
        for (int i = 0; i < 16; i++) pop_byte();
        chk("drained_count", count, 0);
        chk("drained_valid", rd_valid, 0);

        // Pop on empty.
        rd_en = 1'b1;
        step();
        rd_en = 1'b0;
        chk("empty_pop_count", count, 0);
        chk("empty_pop_valid", rd_valid, 0);

        // Streaming across pointer wrap, level never above 2.
        for (int i = 0; i < 40; i++) send_byte(8'((i * 37 + 11) & 8'hFF), (i >= 2), 1'b0);
        while (q.size() > 0) pop_byte();
        chk("wrap_count", count, 0);
        chk("wrap_valid", rd_valid, 0);

        // Reset in the middle of a handshake with five bytes stored.
        for (int i = 0; i < 4; i++) send_byte(8'hD0 + 8'(i), 1'b0, 1'b0);
        dec_byte  = 8'hE5;
        dec_ready = 1'b1;
        step();
        chk("pre_reset_release", dec_release, 1);
        chk("pre_reset_count", count, 5);
        chk("pre_reset_overflow", overflow, 1);
        rst = 1'b1;
        step();
        rst = 1'b0;
        dec_ready = 1'b0;
        q.delete();
        ov_exp = 1'b0;
        chk("reset_release", dec_release, 0);
        chk("reset_count", count, 0);
        chk("reset_valid", rd_valid, 0);
        chk("reset_overflow", overflow, 0);
        chk("reset_full", full, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
